// File: rtl/dcache_port_arbiter_pkg.sv
// Shared encodings for the two-master Dcache port arbiter: FSM states,
// arbitration modes and requester identifiers.
package dcache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dcache_rr_pick.sv
// Combinational winner selection between the two requesters, either
// round-robin against the previous grant or fixed priority with M0 first.
module dcache_rr_pick
  import dcache_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any    = |req;
    winner = M0;
    case (req)
      2'b10:   winner = M1;
      // Tie: fixed mode favours M0, round-robin favours whoever did not go last.
      2'b11:   winner = (ARB_MODE == ARB_FIXED) ? M0 : ~last_grant;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one registered Dcache request port between two masters, holding each
// request through stalls and steering read data back to the issuing master.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wsel,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wsel,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic [DATA_W-1:0]   dcache_data_i,
  input  logic                dcache_stall_i,
  output logic [ADDR_W-1:0]   dcache_raddr_o,
  output logic [ADDR_W-1:0]   dcache_waddr_o,
  output logic [DATA_W-1:0]   dcache_wdata_o,
  output logic                dcache_wreq_o,
  output logic                dcache_rreq_o,
  output logic [DATA_W/8-1:0] dcache_wsel_o
);

  localparam int SEL_W = DATA_W / 8;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   any;
  logic   winner;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [SEL_W-1:0]  sel_wsel;

  dcache_rr_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wsel  = m0_wsel;
    if (winner == M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wsel  = m1_wsel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      last_grant     <= M1;
      owner          <= M0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m1_rvalid      <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      dcache_raddr_o <= '0;
      dcache_waddr_o <= '0;
      dcache_wdata_o <= '0;
      dcache_wreq_o  <= 1'b0;
      dcache_rreq_o  <= 1'b0;
      dcache_wsel_o  <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            if (sel_we) begin
              dcache_waddr_o <= sel_addr;
              dcache_wdata_o <= sel_wdata;
              dcache_wsel_o  <= sel_wsel;
              dcache_wreq_o  <= 1'b1;
            end else begin
              dcache_raddr_o <= sel_addr;
              dcache_wsel_o  <= '1;
              dcache_rreq_o  <= 1'b1;
            end
            m0_gnt     <= (winner == M0);
            m1_gnt     <= (winner == M1);
            last_grant <= winner;
            owner      <= winner;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The request strobe itself remembers whether this was a write.
          if (!dcache_stall_i) begin
            dcache_wreq_o <= 1'b0;
            dcache_rreq_o <= 1'b0;
            state         <= dcache_wreq_o ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!dcache_stall_i) begin
            if (owner == M0) begin
              m0_rdata  <= dcache_data_i;
              m0_rvalid <= 1'b1;
            end else begin
              m1_rdata  <= dcache_data_i;
              m1_rvalid <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single Dcache request port (rreq/wreq, raddr/waddr, wdata, wsel, data_i) between two requesters: M0 (load/store pipeline) and M1 (test driver or store buffer).
- Arbitrates between them, drives registered Dcache requests, holds each request through Dcache stalls, and returns read data to the requester that issued it.
- Only one transaction is outstanding at a time. Sits between the CPU-side masters and the Dcache.

Parameters:
- ADDR_W, 32, address width of requesters and Dcache.
- DATA_W, 32, data width. wsel width is DATA_W/8.
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with M0 winning.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mN_req  in  1  request valid (N = 0,1); held with fields stable until mN_gnt seen
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_wsel  in  DATA_W/8  byte enables for writes
- mN_gnt  out  1  one-cycle pulse: request accepted by arbiter
- mN_rvalid  out  1  one-cycle pulse: mN_rdata valid
- mN_rdata  out  DATA_W  read data
- dcache_data_i  in  DATA_W  Dcache read data
- dcache_stall_i  in  1  Dcache busy; request held while high
- dcache_raddr_o  out  ADDR_W  read address
- dcache_waddr_o  out  ADDR_W  write address
- dcache_wdata_o  out  DATA_W  write data
- dcache_wreq_o  out  1  write request
- dcache_rreq_o  out  1  read request
- dcache_wsel_o  out  DATA_W/8  byte select

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high. All outputs are registered.
- Reset values: every output is 0. State is IDLE. last_grant = 1, so M0 wins the first tie.
- States:
  - IDLE:
    - If no mN_req is high, stay in IDLE.
    - Otherwise select the winner. ARB_MODE=0: a sole requester wins; on a tie the requester not equal to last_grant wins. ARB_MODE=1: M0 always wins a tie.
    - At the same edge:
      - latch the winner's fields into the dcache_* registers;
      - set dcache_wreq_o (we=1) or dcache_rreq_o (we=0);
      - pulse mN_gnt;
      - update last_grant and the owner register;
      - go to ISSUE.
  - ISSUE:
    - dcache_* outputs are held unchanged while dcache_stall_i = 1.
    - At the first edge with stall = 0, clear wreq/rreq.
    - Write: go to IDLE. Read: go to WAIT.
  - WAIT:
    - At the first edge with dcache_stall_i = 0, register dcache_data_i into owner's rdata and pulse owner's rvalid. Go to IDLE.
- Field rules:
  - On a write, drive waddr/wdata/wsel from the requester; raddr holds its previous value.
  - On a read, drive raddr and force wsel to all-ones; waddr and wdata hold their previous values.
  - Addresses pass through unaltered, with no alignment check.
- Arbiter behaviour:
  - mN_req is ignored outside IDLE. A requester must drop req the cycle after sampling gnt, or the arbiter sees it as a new request.
  - The non-owner's rdata holds its value. rvalid is asserted only for the owner.
- Minimum latency, requester req to next grant:
  - write: 2 cycles;
  - read: 3 cycles (gnt at edge 1, rvalid at edge 3 with no stall).
- Boundary conditions:
  - Back-to-back requests from both masters under ARB_MODE=0 strictly alternate M0, M1, M0, …
  - Stall held indefinitely: the FSM holds with no timeout.
  - wsel = 0 on a write is passed through unchanged.
  - rst mid-transaction: the FSM aborts to IDLE, no rvalid or gnt is issued afterwards, and the pending read is lost.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2;
  - ARB_RR = 0, ARB_FIXED = 1;
  - requester IDs M0 = 1'b0, M1 = 1'b1.
- One natural sub-module: dcache_rr_pick. It is combinational winner selection from req[1:0], last_grant and ARB_MODE. Everything else stays in the top.

Test Plan:
- M0 only: write 0x0000BEEF to 0x00000010 with wsel 4'hF, then read 0x10. Required:
  - gnt at edge 1, wreq high exactly 1 cycle, waddr = 0x10;
  - read path: rreq, raddr = 0x10, wsel = 4'hF, m0_rvalid 2 cycles after gnt;
  - m0_rdata equals the model data.
- Both masters request continuously, writing 16 words to addresses i·16, ARB_MODE=0. Required:
  - grants alternate M0, M1, … starting with M0;
  - 32 writes in 64 cycles.
- Same stimulus with ARB_MODE=1. Required: all M0 grants precede the first M1 grant.
- Stall 5 cycles during a read issue, then 3 cycles in WAIT. Required:
  - rreq/raddr stable through the 5 cycles;
  - rvalid 1 cycle after stall falls in WAIT;
  - data correct.
- Reset asserted in WAIT. Required:
  - all outputs 0 next cycle;
  - no rvalid;
  - next request granted to M0.
- M1 read in progress while M0 asserts req. Required: M0 gnt only after M1 rvalid, i.e. the IDLE edge following it.
